memory_access_module: RTL
=========================

# memory_access_module

MEM stage of the 5-stage MIPS pipeline. Consumes the EX/MEM latch outputs of the execution stage: ALU result as address, rt data as store data, destination register, WB/MEM control. Performs byte/half/word loads and stores on an internal synchronous data RAM and registers the MEM/WB latch. Also provides a forwarding value to the hazard unit and a debug read port for the SPI slave.

## Interface
- NB_BITS, 32, datapath width
- NB_ADDR, 10, data RAM word-address width (2^NB_ADDR words)
- NB_REG, `NB_REG (5), register number width
- NB_WB, `NB_CTR_WB (2), WB control width: bit0 reg_write, bit1 mem_to_reg
- NB_MEM, `NB_CTR_MEM (5), MEM control width: bit0 mem_write, bit1 mem_read, bits3:2 size (00 byte, 01 half, 10 word, 11 reserved→word), bit4 unsigned load
---
- i_clk  in  1  clock; one clock domain
- i_rst  in  1  synchronous, active-high reset
- i_debug_enb  in  1  pipeline enable; 0 freezes stage
- i_alu_out  in  NB_BITS  byte address / pass-through ALU result
- i_data_reg  in  NB_BITS  store data (rt)
- i_reg_dst  in  NB_REG  destination register
- i_wb_ctl  in  NB_WB  WB control
- i_mem_ctl  in  NB_MEM  MEM control
- i_from_SPI  in  NB_BITS  debug word address in bits NB_ADDR-1:0
- o_read_data  out  NB_BITS  extended load data (MEM/WB)
- o_alu_out  out  NB_BITS  latched ALU result (MEM/WB)
- o_reg_dst  out  NB_REG  latched destination
- o_wb_ctl  out  NB_WB  latched WB control
- o_mem_wb_reg_hz  out  NB_BITS  mem_to_reg ? o_read_data : o_alu_out, to EX forwarding mux
- o_to_SPI  out  NB_BITS  debug RAM word
- o_misaligned  out  1  sticky misalign flag (only with MEM_MISALIGN_CHECK_EN; else tied 0)

## Operation
- Word index = i_alu_out[NB_ADDR+1:2]; upper address bits ignored (address wraps modulo RAM size). Byte offset = i_alu_out[1:0].
- Little-endian lanes: offset 0 = bits 7:0.
- Store (mem_write=1, enable=1): byte → data[7:0] replicated to all lanes, one byte-enable at offset; half → data[15:0] to lanes selected by offset[1] (0: 15:0, 1: 31:16); word → all lanes.
- Load: RAM output registered. Latched offset, size, and unsigned drive extraction. Byte/half sign-extend unless unsigned=1. Word passes through. mem_read=0: o_read_data = raw RAM word (don't-care to WB).
- mem_write and mem_read both 1: store performed, load data is pre-store contents (read-first).
- MEM/WB latch fields: alu_out, reg_dst, wb_ctl, offset, size, unsigned. RAM port A output register counts as latch.
- i_debug_enb=0: no RAM write, latch and RAM output hold. Debug port keeps operating.
- Debug port B: read-only. o_to_SPI <= RAM[i_from_SPI[NB_ADDR-1:0]] every cycle. Same-cycle port-A write to the same word returns old data.

## Timing
- Reset: all latch fields, RAM output regs, o_to_SPI, o_misaligned = 0; RAM contents not cleared.
- Load latency 1 cycle: address presented cycle n, o_read_data valid after edge n+1.
- Store committed at edge n+1; a load to the same word in cycle n+1 sees new data.
- o_mem_wb_reg_hz combinational from latch, no added latency.
- Reset overrides i_debug_enb. A store in the reset cycle is dropped.

## Configuration
- MEM_MISALIGN_CHECK_EN defined: half with offset[0]=1 or word with offset≠0 is misaligned. Store suppressed (no byte enables). Load o_read_data forced 0. o_misaligned set, held until i_rst.
- Undefined: misaligned low bits ignored (half uses offset[1] only, word ignores offset). o_misaligned constant 0.

## Structure
- Shared include: MEM-control bit positions, size encodings (`SIZE_BYTE/`SIZE_HALF/`SIZE_WORD), WB-control bit positions, `NB_CTR_MEM`, `NB_CTR_WB`.
- Sub-module data_memory: true dual-port RAM. Port A read-first, byte-write-enables, output register with enable and sync reset. Port B read-only registered. Infers block RAM.
- Load extraction/extension and store lane steering stay in the top module.

## Test plan
- Reset with i_rst=1 two cycles → all outputs 0; then SW 0xDEADBEEF @0x10, LW @0x10 → o_read_data=0xDEADBEEF one cycle later.
- SB 0x80 @0x21, LB @0x21 → 0xFFFFFF80; LBU @0x21 → 0x00000080; LW @0x20 shows only bits 15:8 changed.
- SH 0x8001 @0x42, LH → 0xFFFF8001, LHU → 0x00008001.
- i_debug_enb=0 during SW @0x30 → RAM unchanged and latch held. i_from_SPI=0x0C → o_to_SPI = word @0x30 next cycle.
- mem_to_reg=1 load → o_mem_wb_reg_hz=o_read_data; mem_to_reg=0 → equals o_alu_out. Address 0x1000 (NB_ADDR=10) aliases to 0x0.
- MEM_MISALIGN_CHECK_EN: SW @0x13 → no write, o_misaligned=1 persists until reset. Without macro: same SW writes word @0x10.

Source files
------------

// File: rtl/memory_access_module_pkg.sv
// rtl/memory_access_module_pkg.sv - access size type and load extraction helper for the MEM stage
`include "memory_access_module_defs.svh"

package memory_access_module_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = `SIZE_BYTE,
      SZ_HALF = `SIZE_HALF,
      SZ_WORD = `SIZE_WORD,
      SZ_RSVD = 2'b11
   } mem_size_e;

   localparam int NB_LANES = 4;

   // Picks the addressed byte/half out of a little-endian word and extends it.
   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                               input mem_size_e  size,
                                               input logic [1:0] off,
                                               input logic       uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      b = word[8*off +: 8];
      h = off[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_BYTE: res = uns ? {24'b0, b} : {{24{b[7]}}, b};
         SZ_HALF: res = uns ? {16'b0, h} : {{16{h[15]}}, h};
         default: res = word;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/memory_access_module_data_memory.sv
// rtl/memory_access_module_data_memory.sv - true dual-port data RAM: port A read-first with byte enables, port B read-only
module data_memory #(
   parameter int NB_DATA = 32,
   parameter int NB_ADDR = 10,
   parameter int NB_LANE = NB_DATA / 8
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_enb_a,
   input  logic [NB_LANE-1:0] i_we_a,
   input  logic [NB_ADDR-1:0] i_addr_a,
   input  logic [NB_DATA-1:0] i_data_a,
   output logic [NB_DATA-1:0] o_data_a,
   input  logic [NB_ADDR-1:0] i_addr_b,
   output logic [NB_DATA-1:0] o_data_b
);

   logic [NB_DATA-1:0] r_mem [0:(2**NB_ADDR)-1];
   logic [NB_DATA-1:0] r_out_a;
   logic [NB_DATA-1:0] r_out_b;

   always_ff @(posedge i_clk) begin
      if (i_enb_a) begin
         for (int k = 0; k < NB_LANE; k++) begin
            if (i_we_a[k]) r_mem[i_addr_a][8*k +: 8] <= i_data_a[8*k +: 8];
         end
      end
   end

   // Non-blocking reads of r_mem give read-first behaviour on both ports.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_out_a <= '0;
         r_out_b <= '0;
      end else begin
         if (i_enb_a) r_out_a <= r_mem[i_addr_a];
         r_out_b <= r_mem[i_addr_b];
      end
   end

   assign o_data_a = r_out_a;
   assign o_data_b = r_out_b;

endmodule

// File: rtl/memory_access_module_defs.svh
// rtl/memory_access_module_defs.svh - shared MEM/WB control field positions and size encodings
`ifndef MEMORY_ACCESS_MODULE_DEFS_SVH
`define MEMORY_ACCESS_MODULE_DEFS_SVH

`define NB_REG             5
`define NB_CTR_WB          2
`define NB_CTR_MEM         5

`define MEM_WRITE_BIT      0
`define MEM_READ_BIT       1
`define MEM_SIZE_LSB       2
`define MEM_SIZE_MSB       3
`define MEM_UNSIGNED_BIT   4

`define SIZE_BYTE          2'b00
`define SIZE_HALF          2'b01
`define SIZE_WORD          2'b10

`define WB_REG_WRITE_BIT   0
`define WB_MEM_TO_REG_BIT  1

`endif

// File: rtl/memory_access_module.sv
// rtl/memory_access_module.sv - MIPS MEM stage: lane steering, load extension, MEM/WB latch
// Optional MEM_MISALIGN_CHECK_EN: suppress misaligned accesses and raise sticky o_misaligned.
`include "memory_access_module_defs.svh"

module memory_access_module
   import memory_access_module_pkg::*;
#(
   parameter int NB_BITS = 32,
   parameter int NB_ADDR = 10,
   parameter int NB_REG  = `NB_REG,
   parameter int NB_WB   = `NB_CTR_WB,
   parameter int NB_MEM  = `NB_CTR_MEM
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_debug_enb,
   input  logic [NB_BITS-1:0] i_alu_out,
   input  logic [NB_BITS-1:0] i_data_reg,
   input  logic [NB_REG-1:0]  i_reg_dst,
   input  logic [NB_WB-1:0]   i_wb_ctl,
   input  logic [NB_MEM-1:0]  i_mem_ctl,
   input  logic [NB_BITS-1:0] i_from_SPI,
   output logic [NB_BITS-1:0] o_read_data,
   output logic [NB_BITS-1:0] o_alu_out,
   output logic [NB_REG-1:0]  o_reg_dst,
   output logic [NB_WB-1:0]   o_wb_ctl,
   output logic [NB_BITS-1:0] o_mem_wb_reg_hz,
   output logic [NB_BITS-1:0] o_to_SPI,
   output logic               o_misaligned
);

   logic [NB_ADDR-1:0]  w_word_a;
   logic [1:0]          w_off;
   mem_size_e           w_size;
   logic                w_mem_write;
   logic                w_mem_read;
   logic                w_mis;
   logic [NB_LANES-1:0] w_be;
   logic [NB_LANES-1:0] w_we;
   logic [NB_BITS-1:0]  w_wdata;
   logic [NB_BITS-1:0]  w_ram_a;
   logic                w_unused_bits;

   logic [NB_BITS-1:0]  r_alu_out;
   logic [NB_REG-1:0]   r_reg_dst;
   logic [NB_WB-1:0]    r_wb_ctl;
   logic [1:0]          r_off;
   mem_size_e           r_size;
   logic                r_unsigned;
   logic                r_mem_read;
   logic                r_mis;

   // Upper address bits beyond the RAM are ignored: accesses wrap.
   assign w_word_a      = i_alu_out[NB_ADDR+1:2];
   assign w_off         = i_alu_out[1:0];
   assign w_size        = mem_size_e'(i_mem_ctl[`MEM_SIZE_MSB:`MEM_SIZE_LSB]);
   assign w_mem_write   = i_mem_ctl[`MEM_WRITE_BIT];
   assign w_mem_read    = i_mem_ctl[`MEM_READ_BIT];
   assign w_unused_bits = ^{i_alu_out[NB_BITS-1:NB_ADDR+2], i_from_SPI[NB_BITS-1:NB_ADDR]};

`ifdef MEM_MISALIGN_CHECK_EN
   assign w_mis = ((w_size == SZ_HALF) && w_off[0]) ||
                  ((w_size == SZ_WORD || w_size == SZ_RSVD) && (w_off != 2'b00));
`else
   assign w_mis = 1'b0;
`endif

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = i_data_reg;
      case (w_size)
         SZ_BYTE: begin
            w_be    = 4'b0001 << w_off;
            w_wdata = {4{i_data_reg[7:0]}};
         end
         SZ_HALF: begin
            w_be    = w_off[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{i_data_reg[15:0]}};
         end
         default: ;
      endcase
   end

   assign w_we = (w_mem_write && i_debug_enb && !i_rst && !w_mis) ? w_be : 4'b0000;

   data_memory #(
      .NB_DATA (NB_BITS),
      .NB_ADDR (NB_ADDR)
   ) u_data_memory (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_enb_a  (i_debug_enb),
      .i_we_a   (w_we),
      .i_addr_a (w_word_a),
      .i_data_a (w_wdata),
      .o_data_a (w_ram_a),
      .i_addr_b (i_from_SPI[NB_ADDR-1:0]),
      .o_data_b (o_to_SPI)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_alu_out  <= '0;
         r_reg_dst  <= '0;
         r_wb_ctl   <= '0;
         r_off      <= '0;
         r_size     <= SZ_BYTE;
         r_unsigned <= 1'b0;
         r_mem_read <= 1'b0;
         r_mis      <= 1'b0;
      end else if (i_debug_enb) begin
         r_alu_out  <= i_alu_out;
         r_reg_dst  <= i_reg_dst;
         r_wb_ctl   <= i_wb_ctl;
         r_off      <= w_off;
         r_size     <= w_size;
         r_unsigned <= i_mem_ctl[`MEM_UNSIGNED_BIT];
         r_mem_read <= w_mem_read;
         r_mis      <= w_mis && w_mem_read;
      end
   end

`ifdef MEM_MISALIGN_CHECK_EN
   logic r_misaligned;

   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_misaligned <= 1'b0;
      else if (i_debug_enb && w_mis && (w_mem_write || w_mem_read))
         r_misaligned <= 1'b1;
   end

   assign o_misaligned = r_misaligned;
`else
   assign o_misaligned = 1'b0;
`endif

   // Without mem_read the raw word is passed on; WB ignores it.
   always_comb begin
      o_read_data = w_ram_a;
      if (r_mem_read) begin
         if (r_mis) o_read_data = '0;
         else       o_read_data = load_extend(w_ram_a, r_size, r_off, r_unsigned);
      end
   end

   assign o_alu_out       = r_alu_out;
   assign o_reg_dst       = r_reg_dst;
   assign o_wb_ctl        = r_wb_ctl;
   assign o_mem_wb_reg_hz = r_wb_ctl[`WB_MEM_TO_REG_BIT] ? o_read_data : r_alu_out;

endmodule
